// File: rtl/fu_issue_ctrl.sv
// Purpose: binds one ready RS instruction per cycle to a free FU instance and issues it to the FU block.
// Latency: an accept at edge N is presented on fu_issue_out in cycle N+1, or in the first stall-free cycle after it.
// Backpressure: fu_stall or no free instance in the offered class drops rs_ready; a held packet replays until delivered.
//
// Ports:
//   clock, reset        sole clock; synchronous active-high reset
//   rs_valid/rs_class   RS offer and its class (0=ALU, 1=MULT, 2=BRANCH, 3=illegal)
//   rs_packet           instruction payload; the incoming fu_select is overwritten
//   rs_ready            combinational; the offer is accepted at this edge
//   fu_stall            FU completion stall; freezes the held packet
//   fu_rs_in/br_done_in per-instance release pulses
//   fu_issue_out        one-cycle issue packet; all-zero when idle
//   fu_busy             {BRANCH, MULT_1, MULT_2, ALU_1, ALU_2, ALU_3} occupancy

package fu_issue_pkg;

    localparam logic [2:0] FU_NONE   = 3'd0;
    localparam logic [2:0] FU_ALU_1  = 3'd1;
    localparam logic [2:0] FU_ALU_2  = 3'd2;
    localparam logic [2:0] FU_ALU_3  = 3'd3;
    localparam logic [2:0] FU_MULT_1 = 3'd4;
    localparam logic [2:0] FU_MULT_2 = 3'd5;
    localparam logic [2:0] FU_BRANCH = 3'd6;

    localparam logic [1:0] CLS_ALU    = 2'd0;
    localparam logic [1:0] CLS_MULT   = 2'd1;
    localparam logic [1:0] CLS_BRANCH = 2'd2;

    // Bit positions inside the occupancy vector.
    localparam int BIT_ALU_3  = 0;
    localparam int BIT_ALU_2  = 1;
    localparam int BIT_ALU_1  = 2;
    localparam int BIT_MULT_2 = 3;
    localparam int BIT_MULT_1 = 4;
    localparam int BIT_BRANCH = 5;

    typedef struct packed {
        logic        valid;
        logic [2:0]  fu_select;
        logic [7:0]  opcode;
        logic [5:0]  dest_tag;
        logic [31:0] src1;
        logic [31:0] src2;
    } ISSUE_FU_PACKET;

    typedef struct packed {
        logic alu_1;
        logic alu_2;
        logic alu_3;
        logic mult_1;
        logic mult_2;
    } FU_RS_PACKET;

endpackage

module fu_issue_ctrl
    import fu_issue_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           rs_valid,
    input  logic [1:0]     rs_class,
    input  ISSUE_FU_PACKET rs_packet,
    output logic           rs_ready,
    input  logic           fu_stall,
    input  FU_RS_PACKET    fu_rs_in,
    input  logic           br_done_in,
    output ISSUE_FU_PACKET fu_issue_out,
    output logic [5:0]     fu_busy
);

    logic [5:0]     busy_q, busy_d;
    ISSUE_FU_PACKET hold_q, hold_d;
    logic           hold_vld_q, hold_vld_d;

    logic [5:0]     sel_onehot;
    logic [2:0]     sel_code;
    logic           found;
    logic           accept;
    logic [5:0]     rel;

    // Fixed-priority pick of the first free instance in the offered class.
    // Selection looks only at registered occupancy, so a release arriving
    // this cycle does not make its instance selectable until the next one.
    always_comb begin
        sel_onehot = '0;
        sel_code   = FU_NONE;
        found      = 1'b0;
        case (rs_class)
            CLS_ALU: begin
                if (!busy_q[BIT_ALU_1]) begin
                    sel_onehot[BIT_ALU_1] = 1'b1;
                    sel_code              = FU_ALU_1;
                    found                 = 1'b1;
                end else if (!busy_q[BIT_ALU_2]) begin
                    sel_onehot[BIT_ALU_2] = 1'b1;
                    sel_code              = FU_ALU_2;
                    found                 = 1'b1;
                end else if (!busy_q[BIT_ALU_3]) begin
                    sel_onehot[BIT_ALU_3] = 1'b1;
                    sel_code              = FU_ALU_3;
                    found                 = 1'b1;
                end
            end
            CLS_MULT: begin
                if (!busy_q[BIT_MULT_1]) begin
                    sel_onehot[BIT_MULT_1] = 1'b1;
                    sel_code               = FU_MULT_1;
                    found                  = 1'b1;
                end else if (!busy_q[BIT_MULT_2]) begin
                    sel_onehot[BIT_MULT_2] = 1'b1;
                    sel_code               = FU_MULT_2;
                    found                  = 1'b1;
                end
            end
            CLS_BRANCH: begin
                if (!busy_q[BIT_BRANCH]) begin
                    sel_onehot[BIT_BRANCH] = 1'b1;
                    sel_code               = FU_BRANCH;
                    found                  = 1'b1;
                end
            end
            default: begin
                // Illegal class: never accepted.
            end
        endcase
    end

    // Stall blocks acceptance, which is what keeps the held packet intact.
    assign rs_ready = !reset && !fu_stall && found;
    assign accept   = rs_valid && rs_ready;

    assign rel = {br_done_in, fu_rs_in.mult_1, fu_rs_in.mult_2,
                  fu_rs_in.alu_1, fu_rs_in.alu_2, fu_rs_in.alu_3};

    always_comb begin
        // Chosen bit was free, so clearing then setting never conflicts;
        // releases of idle instances fall out as no-ops.
        busy_d = busy_q & ~rel;
        if (accept) begin
            busy_d = busy_d | sel_onehot;
        end

        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (accept) begin
            hold_d           = rs_packet;
            hold_d.valid     = 1'b1;
            hold_d.fu_select = sel_code;
            hold_vld_d       = 1'b1;
        end else if (!fu_stall) begin
            // Whatever was held went out this cycle.
            hold_d     = '0;
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    // A held packet is visible only in stall-free cycles, so it is seen
    // by the FU exactly once.
    assign fu_issue_out = (!reset && hold_vld_q && !fu_stall) ? hold_q : '0;
    assign fu_busy      = reset ? 6'b0 : busy_q;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Purpose: directed, table-driven check of fu_issue_ctrl plus hand-written multi-cycle sequences.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// Backpressure: fu_stall and release pulses are driven directly from the vectors.

module tb_fu_issue_ctrl;
    import fu_issue_pkg::*;

    logic           clock = 1'b0;
    logic           reset;
    logic           rs_valid;
    logic [1:0]     rs_class;
    ISSUE_FU_PACKET rs_packet;
    logic           rs_ready;
    logic           fu_stall;
    FU_RS_PACKET    fu_rs_in;
    logic           br_done_in;
    ISSUE_FU_PACKET fu_issue_out;
    logic [5:0]     fu_busy;

    int checks = 0;
    int errors = 0;

    fu_issue_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .rs_valid     (rs_valid),
        .rs_class     (rs_class),
        .rs_packet    (rs_packet),
        .rs_ready     (rs_ready),
        .fu_stall     (fu_stall),
        .fu_rs_in     (fu_rs_in),
        .br_done_in   (br_done_in),
        .fu_issue_out (fu_issue_out),
        .fu_busy      (fu_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] cls;
        logic       stall;
        logic [4:0] rel;   // {alu_1, alu_2, alu_3, mult_1, mult_2}
        logic       br;
        logic [7:0] tag;
        logic       rdy;
        logic       ovld;
        logic [2:0] osel;
        logic [7:0] otag;
        logic [5:0] busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic vld, input logic [1:0] cls,
                                input logic stall, input logic [4:0] rel, input logic br,
                                input logic [7:0] tag, input logic rdy, input logic ovld,
                                input logic [2:0] osel, input logic [7:0] otag,
                                input logic [5:0] busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.cls = cls; v.stall = stall; v.rel = rel; v.br = br;
        v.tag = tag; v.rdy = rdy; v.ovld = ovld; v.osel = osel; v.otag = otag; v.busy = busy;
        return v;
    endfunction

    // Payload derived from a tag; fu_select is deliberately junk to show it is replaced.
    function automatic ISSUE_FU_PACKET mkpkt(input logic [7:0] tag);
        ISSUE_FU_PACKET p;
        p.valid     = 1'b0;
        p.fu_select = 3'h7;
        p.opcode    = tag;
        p.dest_tag  = tag[5:0];
        p.src1      = {24'hA5A500, tag};
        p.src2      = {tag, 24'h5A5A5A};
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [1:0] cls,
                         input logic stall, input logic [4:0] rel, input logic br,
                         input logic [7:0] tag);
        reset           = rst;
        rs_valid        = vld;
        rs_class        = cls;
        fu_stall        = stall;
        fu_rs_in.alu_1  = rel[4];
        fu_rs_in.alu_2  = rel[3];
        fu_rs_in.alu_3  = rel[2];
        fu_rs_in.mult_1 = rel[1];
        fu_rs_in.mult_2 = rel[0];
        br_done_in      = br;
        rs_packet       = mkpkt(tag);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string pfx, input logic ovld, input logic [2:0] osel,
                           input logic [7:0] otag);
        if (ovld) begin
            chk({pfx, ".valid"}, 32'(fu_issue_out.valid), 32'd1);
            chk({pfx, ".sel"},   32'(fu_issue_out.fu_select), 32'(osel));
            chk({pfx, ".op"},    32'(fu_issue_out.opcode), 32'(otag));
            chk({pfx, ".src1"},  fu_issue_out.src1, {24'hA5A500, otag});
        end else begin
            chk({pfx, ".idle"},  32'(fu_issue_out == '0), 32'd1);
        end
    endtask

    localparam logic [1:0] A = CLS_ALU;
    localparam logic [1:0] M = CLS_MULT;
    localparam logic [1:0] B = CLS_BRANCH;
    localparam logic [1:0] X = 2'd3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        int first_seen;
        logic [2:0] seen_sel;

        // rst vld cls stall rel br tag | rdy ovld osel otag busy
        // Three ALUs fill in priority order, fourth waits for a release.
        vecs.push_back(mk(1,1,A,0,5'b00000,0,8'h00, 0,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h01, 1,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h02, 1,1,FU_ALU_1, 8'h01,6'b000100));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h03, 1,1,FU_ALU_2, 8'h02,6'b000110));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h04, 0,1,FU_ALU_3, 8'h03,6'b000111));
        vecs.push_back(mk(0,1,A,0,5'b01000,0,8'h04, 0,0,FU_NONE,  8'h00,6'b000111));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h04, 1,0,FU_NONE,  8'h00,6'b000101));
        vecs.push_back(mk(0,0,A,0,5'b00000,0,8'h00, 0,1,FU_ALU_2, 8'h04,6'b000111));
        vecs.push_back(mk(0,0,A,0,5'b11100,0,8'h00, 0,0,FU_NONE,  8'h00,6'b000111));
        vecs.push_back(mk(0,0,M,0,5'b00000,0,8'h00, 1,0,FU_NONE,  8'h00,6'b000000));
        // MULT accepted, then three stall cycles: presented once after stall.
        vecs.push_back(mk(0,1,M,0,5'b00000,0,8'h10, 1,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,M,1,5'b00000,0,8'h11, 0,0,FU_NONE,  8'h00,6'b010000));
        vecs.push_back(mk(0,1,M,1,5'b00000,0,8'h11, 0,0,FU_NONE,  8'h00,6'b010000));
        vecs.push_back(mk(0,1,M,1,5'b00000,0,8'h11, 0,0,FU_NONE,  8'h00,6'b010000));
        vecs.push_back(mk(0,0,M,0,5'b00000,0,8'h00, 1,1,FU_MULT_1,8'h10,6'b010000));
        vecs.push_back(mk(0,0,M,0,5'b00010,0,8'h00, 1,0,FU_NONE,  8'h00,6'b010000));
        // Two MULTs back-to-back, third waits for mult_1 release.
        vecs.push_back(mk(0,1,M,0,5'b00000,0,8'h16, 1,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,M,0,5'b00000,0,8'h17, 1,1,FU_MULT_1,8'h16,6'b010000));
        vecs.push_back(mk(0,1,M,0,5'b00000,0,8'h18, 0,1,FU_MULT_2,8'h17,6'b011000));
        vecs.push_back(mk(0,1,M,0,5'b00010,0,8'h18, 0,0,FU_NONE,  8'h00,6'b011000));
        vecs.push_back(mk(0,1,M,0,5'b00000,0,8'h18, 1,0,FU_NONE,  8'h00,6'b001000));
        vecs.push_back(mk(0,0,M,0,5'b00011,0,8'h00, 0,1,FU_MULT_1,8'h18,6'b011000));
        // Illegal class is never ready nor accepted.
        vecs.push_back(mk(0,0,X,0,5'b00000,0,8'h00, 0,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,X,0,5'b00000,0,8'h23, 0,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,0,A,0,5'b00000,0,8'h00, 1,0,FU_NONE,  8'h00,6'b000000));
        // Same-cycle ALU_1 release with all ALUs busy; spurious br_done.
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h25, 1,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h26, 1,1,FU_ALU_1, 8'h25,6'b000100));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h27, 1,1,FU_ALU_2, 8'h26,6'b000110));
        vecs.push_back(mk(0,1,A,0,5'b10000,1,8'h28, 0,1,FU_ALU_3, 8'h27,6'b000111));
        vecs.push_back(mk(0,1,A,0,5'b00000,0,8'h28, 1,0,FU_NONE,  8'h00,6'b000011));
        vecs.push_back(mk(0,0,B,0,5'b00000,0,8'h00, 1,1,FU_ALU_1, 8'h28,6'b000111));
        // BRANCH held under stall, reset discards it, then branch re-issues.
        vecs.push_back(mk(0,1,B,0,5'b00000,0,8'h31, 1,0,FU_NONE,  8'h00,6'b000111));
        vecs.push_back(mk(0,0,B,1,5'b00000,0,8'h00, 0,0,FU_NONE,  8'h00,6'b100111));
        vecs.push_back(mk(1,0,B,1,5'b00000,0,8'h00, 0,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,0,B,0,5'b00000,0,8'h00, 1,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,1,B,0,5'b00000,0,8'h35, 1,0,FU_NONE,  8'h00,6'b000000));
        vecs.push_back(mk(0,0,B,0,5'b00000,0,8'h00, 0,1,FU_BRANCH,8'h35,6'b100000));
        vecs.push_back(mk(0,0,B,0,5'b00000,1,8'h00, 0,0,FU_NONE,  8'h00,6'b100000));
        vecs.push_back(mk(0,0,B,0,5'b00000,0,8'h00, 1,0,FU_NONE,  8'h00,6'b000000));

        drive(1, 0, A, 0, 5'b00000, 0, 8'h00);
        step();
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].cls, vecs[i].stall,
                  vecs[i].rel, vecs[i].br, vecs[i].tag);
            @(negedge clock);
            chk($sformatf("v%0d.rdy", i),  32'(rs_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.busy", i), 32'(fu_busy),  32'(vecs[i].busy));
            chk_out($sformatf("v%0d.out", i), vecs[i].ovld, vecs[i].osel, vecs[i].otag);
            step();
        end

        // Minimum ALU reuse: accept N, release N+2, re-acceptable N+3.
        drive(0, 1, A, 0, 5'b00000, 0, 8'h40);
        @(negedge clock);
        chk("reuse.acc_rdy", 32'(rs_ready), 32'd1);
        step();
        drive(0, 0, A, 0, 5'b00000, 0, 8'h00);
        @(negedge clock);
        chk_out("reuse.out1", 1'b1, FU_ALU_1, 8'h40);
        step();
        drive(0, 0, A, 0, 5'b10000, 0, 8'h00);
        @(negedge clock);
        chk("reuse.busy_at_rel", 32'(fu_busy[2]), 32'd1);
        step();
        drive(0, 1, A, 0, 5'b00000, 0, 8'h41);
        @(negedge clock);
        chk("reuse.busy_after", 32'(fu_busy), 32'd0);
        chk("reuse.rdy", 32'(rs_ready), 32'd1);
        step();
        drive(0, 1, A, 0, 5'b00000, 0, 8'h50);
        @(negedge clock);
        chk_out("reuse.out2", 1'b1, FU_ALU_1, 8'h41);
        step();

        // Stall three cycles; the ALU_2 packet must appear exactly once after.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, A, 1, 5'b00000, 0, 8'h51);
            @(negedge clock);
            chk($sformatf("stall%0d.rdy", k), 32'(rs_ready), 32'd0);
            chk_out($sformatf("stall%0d.out", k), 1'b0, FU_NONE, 8'h00);
            step();
        end
        vcount     = 0;
        first_seen = -1;
        seen_sel   = FU_NONE;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, A, 0, 5'b00000, 0, 8'h00);
            @(negedge clock);
            if (fu_issue_out.valid) begin
                vcount++;
                if (first_seen < 0) begin
                    first_seen = k;
                    seen_sel   = fu_issue_out.fu_select;
                end
            end
            step();
        end
        chk("stall.count", 32'(vcount), 32'd1);
        chk("stall.first", 32'(first_seen), 32'd0);
        chk("stall.sel",   32'(seen_sel), 32'(FU_ALU_2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
